// File: rtl/uart_mul_pkg.sv
// Shared types and widths for the UART multiplier controller slice.
package uart_mul_pkg;

    // Width of one UART byte.
    localparam int BYTE_W    = 8;
    // Width of each multiplier operand.
    localparam int OPERAND_W = 32;
    // Width of the full product.
    localparam int RESULT_W  = 64;
    // Width of the per-state byte counters.
    localparam int CNT_W     = 3;

    // Frame sequencing states of the controller.
    typedef enum logic [2:0] {
        RECV_A,
        RECV_B,
        START,
        WAIT_MUL,
        SEND
    } uart_mul_state_e;

endpackage

// File: rtl/uart_mul_tx_serializer.sv
// Holds the product and streams it out MSB byte first over a valid/ready link.
module uart_mul_tx_serializer
    import uart_mul_pkg::*;
#(
    parameter int NUM_BYTES = 8
) (
    input  logic                i_clk,
    input  logic                i_rstN,
    input  logic                i_load,
    input  logic [RESULT_W-1:0] i_data,
    input  logic                i_txReady,
    output logic [BYTE_W-1:0]   o_txData,
    output logic                o_txValid,
    output logic                o_done
);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    logic [RESULT_W-1:0] r_shift;
    logic [CNT_W-1:0]    r_count;
    logic                r_active;
    logic                w_handshake;

    assign w_handshake = r_active && i_txReady;
    assign o_done      = w_handshake && (r_count == LAST_BYTE);
    assign o_txValid   = r_active;
    assign o_txData    = r_shift[RESULT_W-1 -: BYTE_W];

    // Load the product, then shift one byte out per accepted handshake until the last one.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_shift  <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_shift  <= i_data;
            r_count  <= '0;
            r_active <= 1'b1;
        end else if (w_handshake) begin
            r_shift <= r_shift << BYTE_W;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_BYTE) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_mul_ctrl.sv
// Frame sequencer: collects two big-endian operands from UART, kicks the
// multiplier, and returns the product as a byte stream. OPERAND_BYTES is
// meant to be at most 4 so the 3-bit byte counters cover a whole frame.
module uart_mul_ctrl
    import uart_mul_pkg::*;
#(
    parameter int OPERAND_BYTES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [BYTE_W-1:0]    rx_data_i,
    input  logic                 rx_valid_i,
    output logic [BYTE_W-1:0]    tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [OPERAND_W-1:0] mul_a_o,
    output logic [OPERAND_W-1:0] mul_b_o,
    output logic                 mul_start_o,
    input  logic                 mul_done_i,
    input  logic [RESULT_W-1:0]  mul_result_i,
    output logic                 busy_o,
    output logic                 overrun_o,
    output logic                 timeout_o
);

    // Last byte index of an operand.
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(OPERAND_BYTES - 1);
    // The idle counter only has to reach TIMEOUT_CYCLES-1.
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    // A zero cycle budget turns the timeout off entirely.
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    uart_mul_state_e      r_state;
    uart_mul_state_e      w_stateNext;
    logic [CNT_W-1:0]     r_byteCnt;
    logic [OPERAND_W-1:0] r_opA;
    logic [OPERAND_W-1:0] r_opB;
    logic [IDLE_W-1:0]    r_idle;
    logic                 r_overrun;
    logic                 r_timeout;

    logic w_acceptA;
    logic w_acceptB;
    logic w_accept;
    logic w_drop;
    logic w_idleRun;
    logic w_expire;
    logic w_load;
    logic w_txDone;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RECV_A;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode plus per-cycle accept/drop/timeout decisions.
    always_comb begin
        w_stateNext = r_state;
        w_acceptA   = 1'b0;
        w_acceptB   = 1'b0;
        w_drop      = 1'b0;
        w_idleRun   = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            RECV_A: begin
                w_acceptA = rx_valid_i;
                w_idleRun = (r_byteCnt != '0);
                if (w_acceptA && (r_byteCnt == RX_LAST)) begin
                    w_stateNext = RECV_B;
                end
            end
            RECV_B: begin
                w_acceptB = rx_valid_i;
                w_idleRun = 1'b1;
                if (w_acceptB && (r_byteCnt == RX_LAST)) begin
                    w_stateNext = START;
                end
            end
            START: begin
                w_drop      = rx_valid_i;
                w_stateNext = WAIT_MUL;
            end
            WAIT_MUL: begin
                w_drop = rx_valid_i;
                if (mul_done_i) begin
                    w_load      = 1'b1;
                    w_stateNext = SEND;
                end
            end
            SEND: begin
                w_drop = rx_valid_i;
                if (w_txDone) begin
                    w_stateNext = RECV_A;
                end
            end
            default: begin
                w_stateNext = RECV_A;
            end
        endcase
        w_accept = w_acceptA | w_acceptB;
        // A byte arriving in the expiry cycle wins, so expiry requires a quiet input.
        w_expire = TIMEOUT_EN && w_idleRun && !rx_valid_i && (r_idle == IDLE_LAST);
        if (w_expire) begin
            w_stateNext = RECV_A;
        end
    end

    // Operand shifting, byte/idle counting, and the registered status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_byteCnt <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_idle    <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            r_timeout <= w_expire;
            if (w_expire) begin
                r_byteCnt <= '0;
                r_opA     <= '0;
                r_opB     <= '0;
                r_idle    <= '0;
            end else begin
                if (w_acceptA) begin
                    r_opA <= (r_opA << BYTE_W) | OPERAND_W'(rx_data_i);
                end
                if (w_acceptB) begin
                    r_opB <= (r_opB << BYTE_W) | OPERAND_W'(rx_data_i);
                end
                if (w_stateNext != r_state) begin
                    r_byteCnt <= '0;
                end else if (w_accept) begin
                    r_byteCnt <= r_byteCnt + 1'b1;
                end
                if (w_accept || !w_idleRun) begin
                    r_idle <= '0;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end
        end
    end

    uart_mul_tx_serializer #(
        .NUM_BYTES(2 * OPERAND_BYTES)
    ) u_txSerializer (
        .i_clk    (clk_i),
        .i_rstN   (rst_ni),
        .i_load   (w_load),
        .i_data   (mul_result_i),
        .i_txReady(tx_ready_i),
        .o_txData (tx_data_o),
        .o_txValid(tx_valid_o),
        .o_done   (w_txDone)
    );

    assign mul_a_o     = r_opA;
    assign mul_b_o     = r_opB;
    assign mul_start_o = (r_state == START);
    assign busy_o      = !((r_state == RECV_A) && (r_byteCnt == '0));
    assign overrun_o   = r_overrun;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_uart_mul_ctrl.sv
// Randomized bench for uart_mul_ctrl with a behavioural multiplier and frame model.
module tb_uart_mul_ctrl;

    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic        mul_start_o;
    logic        mul_done_i;
    logic [63:0] mul_result_i;
    logic        busy_o;
    logic        overrun_o;
    logic        timeout_o;

    int checkCount = 0;
    int failCount = 0;
    int startCount = 0;
    int overrunPulses = 0;
    int timeoutPulses = 0;
    int expOverrun = 0;
    int expTimeout = 0;
    int forceLatency = 0;
    logic [31:0] seenA = '0;
    logic [31:0] seenB = '0;

    uart_mul_ctrl #(
        .OPERAND_BYTES (4),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .mul_a_o     (mul_a_o),
        .mul_b_o     (mul_b_o),
        .mul_start_o (mul_start_o),
        .mul_done_i  (mul_done_i),
        .mul_result_i(mul_result_i),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    // Count the single-cycle status pulses.
    always @(negedge clk) begin
        if (overrun_o) overrunPulses++;
        if (timeout_o) timeoutPulses++;
    end

    // Behavioural multiplier: answers each start with the full product after a few cycles.
    initial begin
        int lat;
        mul_done_i   = 1'b0;
        mul_result_i = '0;
        forever begin
            @(negedge clk);
            if (mul_start_o) begin
                startCount++;
                seenA = mul_a_o;
                seenB = mul_b_o;
                lat = (forceLatency > 0) ? forceLatency : $urandom_range(1, 4);
                repeat (lat) @(posedge clk);
                #1;
                mul_result_i = {32'd0, seenA} * {32'd0, seenB};
                mul_done_i   = 1'b1;
                @(posedge clk);
                #1;
                mul_done_i = 1'b0;
            end
        end
    end

    // Hang guard.
    initial begin
        #4000000;
        $display("[TB] FAIL watchdog: got=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
    endtask

    // Send one 8-byte frame and check the returned product byte stream.
    task automatic applyStimulus(input logic [63:0] frame, input int gapIdx, input int gapLen,
                                 input int readyMode, input bit injectOverrun, input int abortAfter);
        logic [31:0] expA;
        logic [31:0] expB;
        logic [63:0] expP;
        logic [7:0]  prevData;
        bit          prevWait;
        int          startsBefore;
        int          n;
        int          cyc;
        int          stallLeft;
        expA = frame[63:32];
        expB = frame[31:0];
        expP = {32'd0, expA} * {32'd0, expB};
        startsBefore = startCount;
        @(negedge clk);
        checkOutput("idleBusy", busy_o, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == gapIdx) repeat (gapLen) @(posedge clk);
            sendByte(frame[63-8*i -: 8]);
        end
        if (injectOverrun) begin
            @(posedge clk);
            #1;
            rx_data_i  = 8'h55;
            rx_valid_i = 1'b1;
            @(posedge clk);
            #1;
            rx_valid_i = 1'b0;
            expOverrun++;
        end
        n = 0;
        cyc = 0;
        stallLeft = 10;
        prevWait = 1'b0;
        prevData = '0;
        while (n < 8 && cyc < 400) begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: tx_ready_i = 1'b1;
                1: tx_ready_i = ($urandom_range(0, 3) != 0);
                default: begin
                    if (n == 2 && stallLeft > 0) begin
                        tx_ready_i = 1'b0;
                        stallLeft--;
                    end else begin
                        tx_ready_i = 1'b1;
                    end
                end
            endcase
            @(negedge clk);
            if (prevWait) checkOutput("txHold", {tx_valid_o, tx_data_o}, {1'b1, prevData});
            prevWait = tx_valid_o && !tx_ready_i;
            prevData = tx_data_o;
            if (tx_valid_o && tx_ready_i) begin
                checkOutput("txByte", tx_data_o, expP[63-8*n -: 8]);
                n++;
                if (abortAfter != 0 && n == abortAfter) break;
            end
            cyc++;
        end
        if (abortAfter == 0) begin
            checkOutput("txCount", n, 8);
            @(posedge clk);
            #1;
            tx_ready_i = 1'b0;
            @(negedge clk);
            checkOutput("endValid", tx_valid_o, 0);
            checkOutput("endBusy", busy_o, 0);
            checkOutput("startCount", startCount - startsBefore, 1);
            checkOutput("mulA", seenA, expA);
            checkOutput("mulB", seenB, expB);
            checkOutput("holdA", mul_a_o, expA);
            checkOutput("holdB", mul_b_o, expB);
            checkOutput("overrunCount", overrunPulses, expOverrun);
            checkOutput("timeoutCount", timeoutPulses, expTimeout);
        end else begin
            checkOutput("abortCount", n, abortAfter);
        end
    endtask

    initial begin
        int toIdx;
        int staleTx;
        logic [63:0] frame;
        rst_ni     = 1'b0;
        rx_data_i  = '0;
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b0;
        #12;
        checkOutput("resetCtl", {tx_data_o, tx_valid_o, mul_start_o, busy_o, overrun_o, timeout_o}, 0);
        checkOutput("resetOps", {mul_a_o, mul_b_o}, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        $display("[TB] basic frame 2 x 4");
        applyStimulus(64'h00000002_00000004, 8, 0, 0, 0, 0);

        $display("[TB] all-ones frame");
        applyStimulus(64'hFFFFFFFF_FFFFFFFF, 8, 0, 0, 0, 0);

        $display("[TB] ten-cycle stall on third TX byte");
        applyStimulus(64'h01234567_89ABCDEF, 8, 0, 2, 0, 0);

        $display("[TB] byte dropped during WAIT_MUL");
        forceLatency = 6;
        applyStimulus(64'h0000ABCD_00001234, 8, 0, 1, 1, 0);
        forceLatency = 0;

        $display("[TB] partial frame timeout");
        expTimeout++;
        sendByte(8'h12);
        sendByte(8'h34);
        sendByte(8'h56);
        @(negedge clk);
        checkOutput("partialBusy", busy_o, 1);
        toIdx = 0;
        for (int k = 2; k <= 150 && toIdx == 0; k++) begin
            @(negedge clk);
            if (timeout_o) toIdx = k;
        end
        checkOutput("timeoutAt", toIdx, TIMEOUT + 1);
        checkOutput("timeoutBusy", busy_o, 0);
        checkOutput("timeoutOpA", mul_a_o, 0);
        @(negedge clk);
        checkOutput("timeoutPulse", timeout_o, 0);
        applyStimulus(64'h00001000_00000300, 8, 0, 1, 0, 0);

        $display("[TB] byte arriving in the expiry cycle");
        applyStimulus(64'h11223344_55667788, 3, TIMEOUT - 2, 1, 0, 0);

        $display("[TB] reset during SEND");
        applyStimulus(64'h00000007_00000009, 8, 0, 0, 0, 4);
        rst_ni = 1'b0;
        #1;
        checkOutput("abortCtl", {tx_data_o, tx_valid_o, mul_start_o, busy_o, overrun_o, timeout_o}, 0);
        checkOutput("abortOps", {mul_a_o, mul_b_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        tx_ready_i = 1'b1;
        staleTx = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_valid_o) staleTx++;
        end
        checkOutput("noStaleTx", staleTx, 0);
        tx_ready_i = 1'b0;
        applyStimulus(64'h00000003_00000005, 8, 0, 0, 0, 0);

        $display("[TB] random frames");
        for (int r = 0; r < 8; r++) begin
            frame = {$urandom, $urandom};
            applyStimulus(frame, $urandom_range(0, 7), $urandom_range(0, 5), 1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
